qspi_flash_responder: RTL and testbench

- Synthesizable QSPI flash target: the responder end of the quad fast-read interface driven by the XIP controller's reader and reset sequencer.
- Decodes the EBh quad I/O read with continuous-read mode and the FFh mode-exit/reset byte, then streams bytes from a backing-memory port.
- Used as the in-system flash stand-in for emulation and as the self-checking counterpart in controller benches.
- Oversamples the host's sck with the system clock.

---
 rtl/qspi_flash_responder.sv | 210 +++++++++++++++++++++
 tb/tb_qspi_flash_responder.sv | 263 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/qspi_flash_responder.sv
// QSPI flash target: decodes EBh quad I/O read (with continuous-read mode) and
// FFh exit, oversamples the host's sck and streams bytes from a memory port.
module qspi_flash_responder #(
    parameter int         DUMMY_CYCLES = 4,
    parameter logic [7:0] CMD_QREAD    = 8'hEB,
    parameter logic [7:0] CMD_EXIT     = 8'hFF
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        sck,
    input  logic        ce_n,
    input  logic [3:0]  din,
    output logic [3:0]  dout,
    output logic        douten,
    output logic [23:0] mem_addr,
    output logic        mem_rd,
    input  logic [7:0]  mem_rdata,
    output logic        cont_mode,
    output logic        cmd_err
);
    typedef enum logic [2:0] {IDLE, CMD, ADDR, MODE, DUMMY, DATA, IGNORE} state_t;

    localparam logic [3:0] DUMMY_LAST = 4'(DUMMY_CYCLES - 1);

    logic [5:0] pins;
    logic [5:0] sync_out;
    logic       sck_s;
    logic       ce_n_s;
    logic [3:0] din_s;

    assign pins = {sck, ce_n, din};

    // Synchronizers clear to "ce_n low" so a frame already in progress at
    // reset release is never mistaken for a fresh chip-enable.
    for (genvar gi = 0; gi < 6; gi++) begin : g_sync
        logic s1_reg;
        logic s2_reg;
        always_ff @(posedge clk) begin
            if (!rst_n) begin
                s1_reg <= 1'b0;
                s2_reg <= 1'b0;
            end else begin
                s1_reg <= pins[gi];
                s2_reg <= s1_reg;
            end
        end
        assign sync_out[gi] = s2_reg;
    end

    assign sck_s  = sync_out[5];
    assign ce_n_s = sync_out[4];
    assign din_s  = sync_out[3:0];

    state_t      state_reg, state_next;
    logic        sck_d_reg;
    logic        armed_reg;
    logic [3:0]  cnt_reg, cnt_next;
    logic [23:0] shift_reg, shift_next;
    logic [1:0]  mode_bits_reg, mode_bits_next;
    logic        nib_lo_reg, nib_lo_next;
    logic [7:0]  byte_reg;
    logic        rd_d_reg;
    logic [3:0]  dout_reg, dout_next;
    logic        douten_reg, douten_next;
    logic [23:0] mem_addr_reg, mem_addr_next;
    logic        mem_rd_reg, mem_rd_next;
    logic        cont_mode_reg, cont_mode_next;
    logic        cmd_err_reg, cmd_err_next;

    logic        rise;
    logic        fall;
    logic [7:0]  cmd_byte;

    assign rise     = sck_s & ~sck_d_reg;
    assign fall     = ~sck_s & sck_d_reg;
    assign cmd_byte = {shift_reg[6:0], din_s[0]};

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_reg <= IDLE;
        end else begin
            state_reg <= state_next;
        end
    end

    always_comb begin
        state_next = state_reg;
        if (ce_n_s) begin
            state_next = IDLE;
        end else begin
            case (state_reg)
                IDLE:   state_next = !armed_reg ? IGNORE : (cont_mode_reg ? ADDR : CMD);
                CMD:    if (rise && cnt_reg == 4'd7)
                            state_next = (cmd_byte == CMD_QREAD) ? ADDR : IGNORE;
                ADDR:   if (rise && cnt_reg == 4'd5) state_next = MODE;
                MODE:   if (rise && cnt_reg == 4'd1) state_next = DUMMY;
                DUMMY:  if (rise && cnt_reg == DUMMY_LAST) state_next = DATA;
                DATA:   state_next = DATA;
                IGNORE: state_next = IGNORE;
                default: state_next = IDLE;
            endcase
        end
    end

    always_comb begin
        cnt_next       = cnt_reg;
        shift_next     = shift_reg;
        mode_bits_next = mode_bits_reg;
        nib_lo_next    = nib_lo_reg;
        dout_next      = dout_reg;
        douten_next    = douten_reg;
        mem_addr_next  = mem_addr_reg;
        mem_rd_next    = 1'b0;
        cont_mode_next = cont_mode_reg;
        cmd_err_next   = 1'b0;

        if (!ce_n_s) begin
            case (state_reg)
                CMD: if (rise) begin
                    shift_next = {shift_reg[22:0], din_s[0]};
                    if (cnt_reg == 4'd7) begin
                        if (cmd_byte == CMD_EXIT)
                            cont_mode_next = 1'b0;
                        else if (cmd_byte != CMD_QREAD)
                            cmd_err_next = 1'b1;
                    end
                end
                ADDR: if (rise) shift_next = {shift_reg[19:0], din_s};
                MODE: if (rise) begin
                    // Only mode bits [5:4] matter; the high nibble arrives first.
                    mode_bits_next = din_s[1:0];
                    if (cnt_reg == 4'd1) begin
                        cont_mode_next = (mode_bits_reg == 2'b10);
                        mem_addr_next  = shift_reg;
                        mem_rd_next    = 1'b1;
                    end
                end
                DATA: if (fall) begin
                    douten_next = 1'b1;
                    if (!nib_lo_reg) begin
                        dout_next = byte_reg[7:4];
                    end else begin
                        dout_next     = byte_reg[3:0];
                        mem_addr_next = mem_addr_reg + 24'd1;
                        mem_rd_next   = 1'b1;
                    end
                    nib_lo_next = ~nib_lo_reg;
                end
                default: ;
            endcase
        end

        if (state_next != DATA) begin
            douten_next = 1'b0;
            dout_next   = 4'd0;
        end

        if (state_next != state_reg) begin
            cnt_next    = 4'd0;
            nib_lo_next = 1'b0;
        end else if (rise) begin
            cnt_next = cnt_reg + 4'd1;
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            sck_d_reg     <= 1'b0;
            armed_reg     <= 1'b0;
            cnt_reg       <= 4'd0;
            shift_reg     <= 24'd0;
            mode_bits_reg <= 2'd0;
            nib_lo_reg    <= 1'b0;
            byte_reg      <= 8'd0;
            rd_d_reg      <= 1'b0;
            dout_reg      <= 4'd0;
            douten_reg    <= 1'b0;
            mem_addr_reg  <= 24'd0;
            mem_rd_reg    <= 1'b0;
            cont_mode_reg <= 1'b0;
            cmd_err_reg   <= 1'b0;
        end else begin
            sck_d_reg     <= sck_s;
            if (ce_n_s)
                armed_reg <= 1'b1;
            cnt_reg       <= cnt_next;
            shift_reg     <= shift_next;
            mode_bits_reg <= mode_bits_next;
            nib_lo_reg    <= nib_lo_next;
            // Memory answers one clk after the strobe; capture it then.
            rd_d_reg      <= mem_rd_reg;
            if (rd_d_reg)
                byte_reg <= mem_rdata;
            dout_reg      <= dout_next;
            douten_reg    <= douten_next;
            mem_addr_reg  <= mem_addr_next;
            mem_rd_reg    <= mem_rd_next;
            cont_mode_reg <= cont_mode_next;
            cmd_err_reg   <= cmd_err_next;
        end
    end

    assign dout      = dout_reg;
    assign douten    = douten_reg;
    assign mem_addr  = mem_addr_reg;
    assign mem_rd    = mem_rd_reg;
    assign cont_mode = cont_mode_reg;
    assign cmd_err   = cmd_err_reg;

endmodule

// File: tb/tb_qspi_flash_responder.sv
// Directed bench for qspi_flash_responder: host drives sck at clk/4 and
// reads nibbles back; memory returns addr[7:0]^5Ah one clk after mem_rd.
module tb_qspi_flash_responder;
    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        sck = 1'b0;
    logic        ce_n = 1'b1;
    logic [3:0]  din = 4'd0;
    logic [3:0]  dout;
    logic        douten;
    logic [23:0] mem_addr;
    logic        mem_rd;
    logic [7:0]  mem_rdata = 8'd0;
    logic        cont_mode;
    logic        cmd_err;

    int n_checks = 0;
    int n_fail = 0;

    always #5 clk = ~clk;

    qspi_flash_responder #(
        .DUMMY_CYCLES(4),
        .CMD_QREAD(8'hEB),
        .CMD_EXIT(8'hFF)
    ) dut (
        .clk(clk),
        .rst_n(rst_n),
        .sck(sck),
        .ce_n(ce_n),
        .din(din),
        .dout(dout),
        .douten(douten),
        .mem_addr(mem_addr),
        .mem_rd(mem_rd),
        .mem_rdata(mem_rdata),
        .cont_mode(cont_mode),
        .cmd_err(cmd_err)
    );

    always @(posedge clk) if (mem_rd) mem_rdata <= mem_addr[7:0] ^ 8'h5A;

    logic [23:0] rd_log[$];
    int err_pulses = 0;
    int drive_cycles = 0;
    always @(negedge clk) begin
        if (mem_rd) rd_log.push_back(mem_addr);
        if (cmd_err) err_pulses++;
        if (douten) drive_cycles++;
    end

    initial begin
        #2ms;
        $display("FAIL watchdog: observed timeout expected completion");
        $fatal(1, "watchdog expired");
    end

    task automatic tick(input int n);
        repeat (n) @(negedge clk);
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic sck_cycle(input logic [3:0] d);
        din = d;
        sck = 1'b0;
        tick(2);
        sck = 1'b1;
        tick(2);
    endtask

    task automatic send_byte1(input logic [7:0] b);
        for (int i = 7; i >= 0; i--) sck_cycle({3'b000, b[i]});
    endtask

    task automatic send_nibbles(input logic [23:0] v, input int n);
        for (int i = n - 1; i >= 0; i--) sck_cycle(v[i*4 +: 4]);
    endtask

    task automatic dummies();
        repeat (4) sck_cycle(4'h0);
    endtask

    // Each nibble is sampled four clks after the fall that launched it.
    task automatic read_byte(output logic [7:0] b);
        sck_cycle(4'h0);
        b[7:4] = dout;
        sck_cycle(4'h0);
        b[3:0] = dout;
    endtask

    task automatic frame_start();
        ce_n = 1'b0;
        tick(3);
    endtask

    task automatic frame_end(input string tag);
        ce_n = 1'b1;
        tick(3);
        chk(tag, {31'd0, douten}, 32'd0);
        sck = 1'b0;
        tick(4);
    endtask

    task automatic chk_all_zero(input string tag);
        chk({tag, "_dout"}, {28'd0, dout}, 32'd0);
        chk({tag, "_douten"}, {31'd0, douten}, 32'd0);
        chk({tag, "_mem_rd"}, {31'd0, mem_rd}, 32'd0);
        chk({tag, "_mem_addr"}, {8'd0, mem_addr}, 32'd0);
        chk({tag, "_cont_mode"}, {31'd0, cont_mode}, 32'd0);
        chk({tag, "_cmd_err"}, {31'd0, cmd_err}, 32'd0);
    endtask

    initial begin
        logic [7:0] rb;
        int base;
        int e0;
        int d0;

        // Power-on reset
        tick(3);
        chk_all_zero("reset");
        rst_n = 1'b1;
        tick(4);
        $display("reset: outputs checked");

        // Basic EBh burst of 4 bytes from 000010
        base = rd_log.size();
        frame_start();
        send_byte1(8'hEB);
        send_nibbles(24'h000010, 6);
        send_nibbles(24'h0000A0, 2);
        dummies();
        chk("dummy_douten", {31'd0, douten}, 32'd0);
        read_byte(rb); chk("basic_b0", {24'd0, rb}, 32'h4A);
        chk("basic_douten", {31'd0, douten}, 32'd1);
        read_byte(rb); chk("basic_b1", {24'd0, rb}, 32'h4B);
        read_byte(rb); chk("basic_b2", {24'd0, rb}, 32'h48);
        read_byte(rb); chk("basic_b3", {24'd0, rb}, 32'h49);
        chk("basic_cont", {31'd0, cont_mode}, 32'd1);
        frame_end("basic_end_douten");
        chk("basic_rd0", {8'd0, rd_log[base]}, 32'h000010);
        chk("basic_rd1", {8'd0, rd_log[base+1]}, 32'h000011);
        chk("basic_rd2", {8'd0, rd_log[base+2]}, 32'h000012);
        chk("basic_rd3", {8'd0, rd_log[base+3]}, 32'h000013);
        $display("basic burst: EBh addr 000010 mode A0, 4 bytes");

        // Continuous-mode frame without opcode
        frame_start();
        send_nibbles(24'h000100, 6);
        send_nibbles(24'h0000A0, 2);
        dummies();
        read_byte(rb); chk("cont_b0", {24'd0, rb}, 32'h5A);
        chk("cont_stays", {31'd0, cont_mode}, 32'd1);
        frame_end("cont_end_douten");
        $display("continuous frame: addr 000100 read %0h", rb);

        // Mode FFh leaves continuous mode
        frame_start();
        send_nibbles(24'h000200, 6);
        send_nibbles(24'h0000FF, 2);
        tick(4);
        chk("modeff_clear", {31'd0, cont_mode}, 32'd0);
        frame_end("modeff_end_douten");
        $display("continuous frame: mode FF exit");

        // Address wrap, opcode required again
        base = rd_log.size();
        frame_start();
        send_byte1(8'hEB);
        send_nibbles(24'hFFFFFE, 6);
        send_nibbles(24'h000000, 2);
        dummies();
        read_byte(rb); chk("wrap_b0", {24'd0, rb}, 32'hA4);
        read_byte(rb); chk("wrap_b1", {24'd0, rb}, 32'hA5);
        read_byte(rb); chk("wrap_b2", {24'd0, rb}, 32'h5A);
        chk("wrap_cont", {31'd0, cont_mode}, 32'd0);
        frame_end("wrap_end_douten");
        chk("wrap_rd0", {8'd0, rd_log[base]}, 32'hFFFFFE);
        chk("wrap_rd1", {8'd0, rd_log[base+1]}, 32'hFFFFFF);
        chk("wrap_rd2", {8'd0, rd_log[base+2]}, 32'h000000);
        $display("wrap frame: addr FFFFFE, 3 bytes");

        // Unsupported opcode 03h
        e0 = err_pulses;
        d0 = drive_cycles;
        frame_start();
        send_byte1(8'h03);
        repeat (12) sck_cycle(4'($urandom_range(0, 15)));
        frame_end("op03_end_douten");
        chk("op03_err_pulses", err_pulses - e0, 32'd1);
        chk("op03_no_drive", drive_cycles - d0, 32'd0);
        $display("opcode 03h frame");

        // Exit opcode FFh with cont_mode clear
        e0 = err_pulses;
        d0 = drive_cycles;
        frame_start();
        send_byte1(8'hFF);
        repeat (12) sck_cycle(4'($urandom_range(0, 15)));
        frame_end("opff_end_douten");
        chk("opff_err_pulses", err_pulses - e0, 32'd0);
        chk("opff_no_drive", drive_cycles - d0, 32'd0);
        chk("opff_cont", {31'd0, cont_mode}, 32'd0);
        $display("opcode FFh frame");

        // Abort mid-byte in DATA
        frame_start();
        send_byte1(8'hEB);
        send_nibbles(24'h000030, 6);
        send_nibbles(24'h000000, 2);
        dummies();
        read_byte(rb); chk("abort_b0", {24'd0, rb}, 32'h6A);
        sck_cycle(4'h0);
        chk("abort_mid_douten", {31'd0, douten}, 32'd1);
        chk("abort_mid_dout", {28'd0, dout}, 32'h6);
        frame_end("abort_douten_3clk");
        frame_start();
        send_byte1(8'hEB);
        send_nibbles(24'h000040, 6);
        send_nibbles(24'h000000, 2);
        dummies();
        read_byte(rb); chk("after_abort_b0", {24'd0, rb}, 32'h1A);
        frame_end("after_abort_end_douten");
        $display("abort frame and recovery frame");

        // Reset during DATA with ce_n held low
        frame_start();
        send_byte1(8'hEB);
        send_nibbles(24'h000050, 6);
        send_nibbles(24'h0000A0, 2);
        dummies();
        read_byte(rb); chk("rst_pre_b0", {24'd0, rb}, 32'h0A);
        chk("rst_pre_cont", {31'd0, cont_mode}, 32'd1);
        rst_n = 1'b0;
        tick(2);
        chk_all_zero("rst_data");
        rst_n = 1'b1;
        e0 = err_pulses;
        d0 = drive_cycles;
        repeat (16) sck_cycle(4'($urandom_range(0, 15)));
        chk("rst_no_drive", drive_cycles - d0, 32'd0);
        chk("rst_no_err", err_pulses - e0, 32'd0);
        frame_end("rst_end_douten");
        frame_start();
        send_byte1(8'hEB);
        send_nibbles(24'h000060, 6);
        send_nibbles(24'h000000, 2);
        dummies();
        read_byte(rb); chk("after_rst_b0", {24'd0, rb}, 32'h3A);
        frame_end("after_rst_end_douten");
        $display("reset during data and recovery frame");

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end
endmodule
